// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and lane helpers for the Memory-stage data responder.
package mem_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        MERGE = 2'd2
    } state_e;

    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lane,
                                                 input logic        uns);
        logic [31:0] res;
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_HALF: res = {{16{h[15] & ~uns}}, h};
            SIZE_BYTE: res = {{24{b[7] & ~uns}}, b};
            default:   res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane);
        logic [31:0] res;
        case (size)
            SIZE_HALF: res = lane[1] ? {wdata[15:0], old[15:0]} : {old[31:16], wdata[15:0]};
            SIZE_BYTE: begin
                case (lane)
                    2'd0:    res = {old[31:8], wdata[7:0]};
                    2'd1:    res = {old[31:16], wdata[7:0], old[7:0]};
                    2'd2:    res = {old[31:24], wdata[7:0], old[15:0]};
                    default: res = {wdata[7:0], old[23:0]};
                endcase
            end
            default:   res = wdata;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Memory-stage data-access bus between the pipeline (master) and the responder (slave).
interface data_mem_responder_if;
    logic        ReqValid;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqUnsigned;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic        Stall;
    logic [31:0] RData;
    logic        RValid;
    logic        AlignErr;

    modport master (
        output ReqValid, ReqWrite, ReqSize, ReqUnsigned, Addr, WData,
        input  Stall, RData, RValid, AlignErr
    );

    modport slave (
        input  ReqValid, ReqWrite, ReqSize, ReqUnsigned, Addr, WData,
        output Stall, RData, RValid, AlignErr
    );
endinterface

// File: rtl/data_ram_sync.sv
// Single-port synchronous RAM with registered read and no reset on the array.
module data_ram_sync #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: word stores in one cycle, loads and sub-word read-modify-write in two.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 512
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    data_mem_responder_if.slave   io_bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_e           r_state;
    state_e           w_state_next;
    logic [1:0]       r_size;
    logic [1:0]       r_lane;
    logic             r_unsigned;
    logic [15:0]      r_wdata;
    logic [AW-1:0]    r_idx;

    logic             w_is_word;
    logic             w_misalign;
    logic             w_latch;
    logic             w_we;
    logic [AW-1:0]    w_ram_addr;
    logic [WIDTH-1:0] w_ram_wdata;
    logic [WIDTH-1:0] w_ram_rdata;
    logic             w_unused_addr;

    // Reserved size code behaves as a word access.
    assign w_is_word  = (io_bus.ReqSize == SIZE_WORD) || (io_bus.ReqSize == SIZE_RSVD);
    assign w_misalign = ((io_bus.ReqSize == SIZE_HALF) && io_bus.Addr[0]) ||
                        (w_is_word && (io_bus.Addr[1:0] != 2'b00));
    assign w_latch    = (r_state == IDLE) && io_bus.ReqValid && !w_misalign &&
                        !(io_bus.ReqWrite && w_is_word);
    assign w_unused_addr = ^io_bus.Addr[31:AW+2];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_size     <= 2'b00;
            r_lane     <= 2'b00;
            r_unsigned <= 1'b0;
            r_wdata    <= 16'h0000;
            r_idx      <= '0;
        end else if (w_latch) begin
            r_size     <= io_bus.ReqSize;
            r_lane     <= io_bus.Addr[1:0];
            r_unsigned <= io_bus.ReqUnsigned;
            r_wdata    <= io_bus.WData[15:0];
            r_idx      <= io_bus.Addr[AW+1:2];
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:        if (w_latch) w_state_next = io_bus.ReqWrite ? MERGE : LOAD;
            LOAD, MERGE: w_state_next = IDLE;
            default:     w_state_next = IDLE;
        endcase
    end

    // Every output and the RAM write enable are forced low while reset is held.
    always_comb begin
        io_bus.Stall    = 1'b0;
        io_bus.RValid   = 1'b0;
        io_bus.RData    = '0;
        io_bus.AlignErr = 1'b0;
        w_we            = 1'b0;
        w_ram_addr      = r_idx;
        w_ram_wdata     = lane_merge(w_ram_rdata, {16'h0000, r_wdata}, r_size, r_lane);
        if (!i_rst) begin
            case (r_state)
                IDLE: begin
                    w_ram_addr  = io_bus.Addr[AW+1:2];
                    w_ram_wdata = io_bus.WData;
                    if (io_bus.ReqValid) begin
                        if (w_misalign) begin
                            io_bus.AlignErr = 1'b1;
                        end else if (io_bus.ReqWrite && w_is_word) begin
                            w_we = 1'b1;
                        end else begin
                            io_bus.Stall = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    io_bus.RValid = 1'b1;
                    io_bus.RData  = lane_extract(w_ram_rdata, r_size, r_lane, r_unsigned);
                end
                MERGE:   w_we = 1'b1;
                default: ;
            endcase
        end
    end

    data_ram_sync #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder against a little-endian byte-array memory model.
module tb_data_mem_responder;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_mem_responder_if bus ();

    data_mem_responder #(
        .WIDTH (32),
        .DEPTH (512)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    logic [7:0]  model [2048];
    logic [31:0] exp_q [$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                               input logic [31:0] addr);
        logic [10:0] a;
        logic [7:0]  b;
        logic [15:0] h;
        a = addr[10:0];
        if (sz == SIZE_BYTE) begin
            b = model[a];
            return uns ? {24'h0, b} : {{24{b[7]}}, b};
        end else if (sz == SIZE_HALF) begin
            h = {model[a + 11'd1], model[a]};
            return uns ? {16'h0, h} : {{16{h[15]}}, h};
        end
        return {model[a + 11'd3], model[a + 11'd2], model[a + 11'd1], model[a]};
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [31:0] addr,
                               input logic [31:0] wd);
        logic [10:0] a;
        a = addr[10:0];
        if (sz == SIZE_BYTE) begin
            model[a] = wd[7:0];
        end else if (sz == SIZE_HALF) begin
            model[a]         = wd[7:0];
            model[a + 11'd1] = wd[15:8];
        end else begin
            for (int k = 0; k < 4; k++) model[a + 11'(k)] = wd[8*k +: 8];
        end
    endtask

    // Called just after a rising edge; returns just after the edge that completes the request.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input string tag);
        logic is_word;
        logic misal;
        int   stalls;
        int   rv;
        is_word = (sz == SIZE_WORD) || (sz == SIZE_RSVD);
        misal   = ((sz == SIZE_HALF) && addr[0]) || (is_word && (addr[1:0] != 2'b00));
        bus.ReqValid    = 1'b1;
        bus.ReqWrite    = wr;
        bus.ReqSize     = sz;
        bus.ReqUnsigned = uns;
        bus.Addr        = addr;
        bus.WData       = wd;
        if (!wr && !misal) exp_q.push_back(model_load(sz, uns, addr));
        stalls = 0;
        rv     = 0;
        @(negedge clk);
        check_eq({tag, "_alignerr"}, {31'h0, bus.AlignErr}, {31'h0, misal});
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            if (bus.RValid) begin
                rv++;
                if (exp_q.size() > 0) check_eq({tag, "_rdata"}, bus.RData, exp_q.pop_front());
            end
            if (!bus.Stall) break;
            stalls++;
        end
        check_eq({tag, "_stalls"}, stalls, (misal || (wr && is_word)) ? 0 : 1);
        check_eq({tag, "_rvalids"}, rv, (!wr && !misal) ? 1 : 0);
        @(posedge clk);
        #1;
        bus.ReqValid = 1'b0;
        if (wr && !misal) model_store(sz, addr, wd);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) model[i] = 8'h00;
        rst             = 1'b1;
        bus.ReqValid    = 1'b1;
        bus.ReqWrite    = 1'b0;
        bus.ReqSize     = SIZE_WORD;
        bus.ReqUnsigned = 1'b0;
        bus.Addr        = 32'h0;
        bus.WData       = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_stall", {31'h0, bus.Stall}, 32'h0);
        check_eq("reset_rvalid", {31'h0, bus.RValid}, 32'h0);
        check_eq("reset_alignerr", {31'h0, bus.AlignErr}, 32'h0);
        check_eq("reset_rdata", bus.RData, 32'h0);
        bus.ReqValid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Word round trip
        issue(1'b1, SIZE_WORD, 1'b0, 32'h10, 32'hDEADBEEF, "st_w10");
        issue(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, "ld_w10");

        // Byte store and signed/unsigned reload
        issue(1'b1, SIZE_WORD, 1'b0, 32'h10, 32'h00000000, "clr_w10");
        issue(1'b1, SIZE_BYTE, 1'b0, 32'h11, 32'h00000080, "st_b11");
        issue(1'b0, SIZE_BYTE, 1'b0, 32'h11, 32'h0, "ld_sb11");
        issue(1'b0, SIZE_BYTE, 1'b1, 32'h11, 32'h0, "ld_ub11");
        issue(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, "ld_w10b");

        // Half store into upper lane
        issue(1'b1, SIZE_WORD, 1'b0, 32'h20, 32'h11223344, "st_w20");
        issue(1'b1, SIZE_HALF, 1'b0, 32'h22, 32'hFFFFA5A5, "st_h22");
        issue(1'b0, SIZE_WORD, 1'b0, 32'h20, 32'h0, "ld_w20");
        issue(1'b0, SIZE_HALF, 1'b0, 32'h22, 32'h0, "ld_sh22");
        issue(1'b0, SIZE_HALF, 1'b1, 32'h20, 32'h0, "ld_uh20");

        // Misaligned accesses leave memory untouched
        issue(1'b0, SIZE_HALF, 1'b0, 32'h21, 32'h0, "mis_h21");
        issue(1'b0, SIZE_WORD, 1'b0, 32'h22, 32'h0, "mis_w22");
        issue(1'b1, SIZE_WORD, 1'b0, 32'h23, 32'h55555555, "mis_sw23");
        issue(1'b1, SIZE_HALF, 1'b0, 32'h21, 32'h00007777, "mis_sh21");
        issue(1'b0, SIZE_WORD, 1'b0, 32'h20, 32'h0, "ld_w20b");

        // Address wrap and reserved size
        issue(1'b1, SIZE_WORD, 1'b0, 32'h800, 32'hCAFEF00D, "st_w800");
        issue(1'b0, SIZE_WORD, 1'b0, 32'h000, 32'h0, "ld_w000");
        issue(1'b1, SIZE_RSVD, 1'b0, 32'h40, 32'h87654321, "st_r40");
        issue(1'b0, SIZE_RSVD, 1'b0, 32'h40, 32'h0, "ld_r40");

        // Reset during MERGE drops the pending write
        issue(1'b1, SIZE_WORD, 1'b0, 32'h30, 32'h12345678, "st_w30");
        bus.ReqValid = 1'b1;
        bus.ReqWrite = 1'b1;
        bus.ReqSize  = SIZE_BYTE;
        bus.Addr     = 32'h30;
        bus.WData    = 32'h000000AB;
        @(negedge clk);
        check_eq("merge_stall", {31'h0, bus.Stall}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("rst_mid_stall", {31'h0, bus.Stall}, 32'h0);
        check_eq("rst_mid_rvalid", {31'h0, bus.RValid}, 32'h0);
        check_eq("rst_mid_alignerr", {31'h0, bus.AlignErr}, 32'h0);
        check_eq("rst_mid_rdata", bus.RData, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_hold_stall", {31'h0, bus.Stall}, 32'h0);
        bus.ReqValid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(1'b0, SIZE_WORD, 1'b0, 32'h30, 32'h0, "ld_w30");

        // Randomised traffic over a pre-seeded window, upper address bits random
        for (int i = 0; i < 16; i++) begin
            issue(1'b1, SIZE_WORD, 1'b0, 32'(i * 4), $urandom, "seed");
        end
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            sz = 2'($urandom_range(0, 3));
            a  = ($urandom & 32'hFFFF_F800) | 32'($urandom_range(0, 63));
            if (sz == SIZE_HALF) a[0] = 1'b0;
            else if (sz != SIZE_BYTE) a[1:0] = 2'b00;
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, "rnd");
        end

        check_eq("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
